// File: rtl/expu_job_ctrl.sv
// ---------------------------------------------------------------------------
// expu_job_ctrl : job sequencer feeding expu_top with strobed, credit-bounded beats
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module expu_job_ctrl #(
   parameter int N_ROWS          = 8,
   parameter int WIDTH           = 16,
   parameter int LEN_W           = 16,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cfg_valid_i,
   output logic                      cfg_ready_o,
   input  logic [LEN_W-1:0]          cfg_len_i,
   input  logic                      abort_i,
   output logic                      busy_o,
   output logic                      done_o,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [N_ROWS*WIDTH-1:0]   in_data_i,
   output logic                      expu_enable_o,
   output logic                      expu_clear_o,
   output logic                      expu_valid_o,
   input  logic                      expu_ready_i,
   output logic [N_ROWS-1:0]         expu_strb_o,
   output logic [N_ROWS*WIDTH-1:0]   expu_op_o,
   input  logic                      expu_valid_i,
   output logic                      expu_ready_o,
   input  logic [N_ROWS*WIDTH-1:0]   expu_res_i,
   input  logic [N_ROWS-1:0]         expu_strb_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [N_ROWS*WIDTH-1:0]   out_data_o,
   output logic [N_ROWS-1:0]         out_strb_o,
   output logic                      out_last_o
);

   localparam int TAIL_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;

   logic [1:0]        state;
   logic [LEN_W-1:0]  beats;
   logic [LEN_W-1:0]  issued;
   logic [LEN_W-1:0]  retired;
   logic [TAIL_W-1:0] tail;
   logic              done_q;
   logic              clear_q;

   logic [LEN_W-1:0]  len_quot;
   logic [TAIL_W-1:0] len_rem;
   logic [LEN_W-1:0]  beats_next;
   logic [LEN_W-1:0]  beats_m1;
   logic [LEN_W-1:0]  outstanding;
   logic [N_ROWS-1:0] tail_mask;
   logic              run_act;
   logic              issue_hs;
   logic              retire_hs;

   // Quotient plus a carry-in for the remainder: cannot overflow at 2^LEN_W-1.
   assign len_quot   = cfg_len_i / LEN_W'(N_ROWS);
   assign len_rem    = TAIL_W'(cfg_len_i % LEN_W'(N_ROWS));
   assign beats_next = len_quot + {{(LEN_W-1){1'b0}}, (len_rem != '0)};

   assign beats_m1    = beats - LEN_W'(1);
   assign outstanding = issued - retired;

   // Abort wins over both handshakes in the cycle it is seen.
   assign run_act = (state == RUN) & ~abort_i;

   always_comb begin
      tail_mask = '0;
      for (int i = 0; i < N_ROWS; i++) begin
         tail_mask[i] = (TAIL_W'(i) < tail);
      end
   end

   assign cfg_ready_o   = (state == IDLE);
   assign busy_o        = (state != IDLE);
   assign expu_enable_o = (state == RUN) | (state == FLUSH);
   assign done_o        = done_q;
   assign expu_clear_o  = clear_q;

   assign expu_valid_o = run_act & in_valid_i & (issued < beats) &
                         (outstanding < LEN_W'(MAX_OUTSTANDING));
   assign in_ready_o   = expu_valid_o & expu_ready_i;
   assign expu_op_o    = (state == RUN) ? in_data_i : '0;
   assign expu_strb_o  = (state != RUN)                          ? '0 :
                         ((issued == beats_m1) && (tail != '0)) ? tail_mask : '1;

   assign out_valid_o  = run_act & expu_valid_i;
   assign expu_ready_o = run_act & out_ready_i;
   assign out_data_o   = (state == RUN) ? expu_res_i : '0;
   assign out_strb_o   = (state == RUN) ? expu_strb_i : '0;
   assign out_last_o   = out_valid_o & (retired == beats_m1);

   assign issue_hs  = in_ready_o;
   assign retire_hs = out_valid_o & out_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         beats   <= '0;
         tail    <= '0;
         issued  <= '0;
         retired <= '0;
         done_q  <= 1'b0;
         clear_q <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         clear_q <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_valid_i) begin
                  if (cfg_len_i == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state   <= RUN;
                     beats   <= beats_next;
                     tail    <= len_rem;
                     issued  <= '0;
                     retired <= '0;
                  end
               end
            end
            RUN: begin
               if (abort_i) begin
                  state   <= FLUSH;
                  clear_q <= 1'b1;
               end else begin
                  if (issue_hs) begin
                     issued <= issued + LEN_W'(1);
                  end
                  if (retire_hs) begin
                     if (out_last_o) begin
                        state   <= IDLE;
                        done_q  <= 1'b1;
                        beats   <= '0;
                        tail    <= '0;
                        issued  <= '0;
                        retired <= '0;
                     end else begin
                        retired <= retired + LEN_W'(1);
                     end
                  end
               end
            end
            FLUSH: begin
               state   <= IDLE;
               beats   <= '0;
               tail    <= '0;
               issued  <= '0;
               retired <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_expu_job_ctrl.sv
// ---------------------------------------------------------------------------
// tb_expu_job_ctrl : randomized directed-sequence bench with a job-level reference model
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_expu_job_ctrl;

   localparam int N  = 8;
   localparam int W  = 16;
   localparam int LW = 16;
   localparam int MO = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            cfg_valid = 1'b0;
   logic            cfg_ready;
   logic [LW-1:0]   cfg_len = '0;
   logic            abort = 1'b0;
   logic            busy;
   logic            done;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [N*W-1:0]  in_data = '0;
   logic            expu_enable;
   logic            expu_clear;
   logic            expu_valid_o;
   logic            expu_ready_in = 1'b0;
   logic [N-1:0]    expu_strb_o;
   logic [N*W-1:0]  expu_op;
   logic            expu_valid_in = 1'b0;
   logic            expu_ready_o;
   logic [N*W-1:0]  expu_res = '0;
   logic [N-1:0]    expu_strb_in = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [N*W-1:0]  out_data;
   logic [N-1:0]    out_strb;
   logic            out_last;

   always #5 clk = ~clk;

   expu_job_ctrl #(.N_ROWS(N), .WIDTH(W), .LEN_W(LW), .MAX_OUTSTANDING(MO)) dut (
      .clk_i(clk), .rst_i(rst),
      .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_len_i(cfg_len),
      .abort_i(abort), .busy_o(busy), .done_o(done),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .expu_enable_o(expu_enable), .expu_clear_o(expu_clear),
      .expu_valid_o(expu_valid_o), .expu_ready_i(expu_ready_in),
      .expu_strb_o(expu_strb_o), .expu_op_o(expu_op),
      .expu_valid_i(expu_valid_in), .expu_ready_o(expu_ready_o),
      .expu_res_i(expu_res), .expu_strb_i(expu_strb_in),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_data_o(out_data), .out_strb_o(out_strb), .out_last_o(out_last)
   );

   typedef struct {
      logic [N*W-1:0] op;
      logic [N-1:0]   strb;
      int             age;
      int             lat;
   } pent_t;

   int n_assert = 0;
   int n_fail   = 0;

   // Job-level reference: 0 idle, 1 running, 2 flushing.
   int phase = 0;
   int beats_e = 0, tail_e = 0, iss = 0, ret = 0, acc = 0;
   logic exp_done = 1'b0, exp_clear = 1'b0;
   logic [N*W-1:0] src_q[$];
   pent_t pipe[$];
   int in_mode = 1, out_mode = 1, er_mode = 1;

   task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [N-1:0] exp_strb(input int k);
      if (k == beats_e - 1 && tail_e != 0) return N'((1 << tail_e) - 1);
      return '1;
   endfunction

   function automatic logic pick(input int mode);
      if (mode == 1) return 1'b1;
      if (mode == 2) return 1'b0;
      return ($urandom_range(0, 3) != 0);
   endfunction

   task automatic cycle(input logic cv, input logic [LW-1:0] clen, input logic ab, input logic rs);
      logic ev, ov, ihs, rhs, s_ev, s_er, s_eri, s_evi;
      logic [N-1:0] s_strb;
      logic [N*W-1:0] s_in;
      pent_t ent;
      int L;
      @(negedge clk);
      rst = rs; cfg_valid = cv; cfg_len = clen; abort = ab;
      while (src_q.size() <= iss) src_q.push_back({$urandom, $urandom, $urandom, $urandom});
      in_data       = src_q[iss];
      in_valid      = pick(in_mode);
      out_ready     = pick(out_mode);
      expu_ready_in = pick(er_mode);
      if (pipe.size() > 0 && pipe[0].age >= pipe[0].lat) begin
         expu_valid_in = 1'b1; expu_res = ~pipe[0].op; expu_strb_in = pipe[0].strb;
      end else begin
         expu_valid_in = 1'b0; expu_res = {$urandom, $urandom, $urandom, $urandom};
         expu_strb_in = N'($urandom);
      end
      #1;
      s_ev = expu_valid_o; s_er = expu_ready_o; s_eri = expu_ready_in;
      s_evi = expu_valid_in; s_strb = expu_strb_o; s_in = in_data;
      if (in_ready) acc++;
      chk("cfg_ready", cfg_ready, phase == 0);
      chk("busy", busy, phase != 0);
      chk("enable", expu_enable, phase != 0);
      ihs = 1'b0; rhs = 1'b0;
      if (!rs && !(phase == 1 && ab)) begin
         ev = (phase == 1) && in_valid && (iss < beats_e) && ((iss - ret) < MO);
         chk("expu_valid", expu_valid_o, ev);
         chk("in_ready", in_ready, ev && expu_ready_in);
         ov = (phase == 1) && expu_valid_in;
         chk("out_valid", out_valid, ov);
         chk("expu_ready", expu_ready_o, (phase == 1) && out_ready);
         if (ev && expu_ready_in) begin
            chk("expu_op", expu_op, in_data);
            chk("expu_strb", expu_strb_o, exp_strb(iss));
            ihs = 1'b1;
         end
         if (ov && out_ready) begin
            chk("out_data", out_data, ~src_q[ret]);
            chk("out_strb", out_strb, exp_strb(ret));
            chk("out_last", out_last, ret == beats_e - 1);
            rhs = 1'b1;
         end
         if (phase == 0) begin
            chk("idle_strb", expu_strb_o, '0);
            chk("idle_data", out_data, '0);
         end
      end
      @(posedge clk);
      #1;
      exp_done = 1'b0; exp_clear = 1'b0;
      // Fake EXPU: variable-latency FIFO that returns the inverted operand.
      if (s_evi && s_er) void'(pipe.pop_front());
      foreach (pipe[i]) pipe[i].age = pipe[i].age + 1;
      if (s_ev && s_eri) begin
         ent.op = s_in; ent.strb = s_strb; ent.age = 0; ent.lat = int'($urandom_range(1, 3));
         pipe.push_back(ent);
      end
      if (rs) begin
         phase = 0; iss = 0; ret = 0; pipe.delete(); src_q.delete();
      end else if (phase == 0) begin
         if (cv) begin
            L = int'(clen);
            if (L == 0) exp_done = 1'b1;
            else begin
               phase = 1; beats_e = (L + N - 1) / N; tail_e = L % N;
               iss = 0; ret = 0; acc = 0; src_q.delete();
            end
         end
      end else if (phase == 1) begin
         if (ab) begin
            phase = 2; exp_clear = 1'b1; pipe.delete();
         end else begin
            iss += int'(ihs); ret += int'(rhs);
            if (rhs && ret == beats_e) begin phase = 0; exp_done = 1'b1; end
         end
      end else begin
         phase = 0; iss = 0; ret = 0;
      end
      chk("done", done, exp_done);
      chk("expu_clear", expu_clear, exp_clear);
   endtask

   task automatic run_job(input int len, input int im, input int om, input int em,
                          input int abort_at, input int rst_at, input int block);
      int n;
      bit aborted, rsted, ab, rs;
      aborted = 0; rsted = 0; n = 0;
      in_mode = im; out_mode = om; er_mode = em;
      acc = 0;
      cycle(1'b1, LW'(len), 1'b0, 1'b0);
      while (phase != 0 && n < 20000) begin
         if (block > 0 && n == block) begin
            chk("cap_accepted", acc, MO);
            chk("cap_valid_low", expu_valid_o, 1'b0);
            out_mode = 1;
         end
         ab = (abort_at >= 0) && (phase == 1) && (iss == abort_at) && !aborted;
         rs = (rst_at >= 0) && (phase == 1) && (iss == rst_at) && !rsted;
         if (ab) aborted = 1;
         if (rs) rsted = 1;
         cycle(1'b0, LW'($urandom), ab, rs);
         n++;
      end
      if (n >= 20000) begin
         n_assert++; n_fail++;
         $error("FAIL job_timeout observed=busy expected=idle len=%0d", len);
      end else if (len != 0 && !aborted && !rsted) begin
         chk("src_accepted", acc, (len + N - 1) / N);
      end
      cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      int len, ab_at;
      repeat (2) @(posedge clk);
      cycle(1'b0, '0, 1'b0, 1'b0);
      run_job(64, 1, 1, 1, -1, -1, 0);
      run_job(13, 1, 1, 1, -1, -1, 0);
      run_job(0, 1, 1, 1, -1, -1, 0);
      run_job(128, 1, 2, 1, -1, -1, 30);
      run_job(64, 1, 1, 1, 3, -1, 0);
      run_job(8, 1, 1, 1, -1, -1, 0);
      run_job(80, 1, 1, 1, -1, 5, 0);
      run_job(24, 1, 1, 1, -1, -1, 0);
      for (int j = 0; j < 14; j++) begin
         len = int'($urandom_range(0, 70));
         ab_at = (len > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, (len + N - 1) / N - 1)) : -1;
         run_job(len, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)), ab_at, -1, 0);
      end
      run_job(65535, 1, 1, 1, -1, -1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
